// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage indices, GRF address / Tnew widths,
// the scoreboard entry record and the saturating Tnew decrement.
package pipe_pkg;

    localparam int STG_D = 0;
    localparam int STG_E = 1;
    localparam int STG_M = 2;
    localparam int STG_W = 3;

    localparam int AW = 5;
    localparam int TW = 2;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [TW-1:0] tnew;
    } sb_entry_t;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? t : t - TW'(1);
    endfunction

endpackage

// File: rtl/sb_port_match.sv
// One D-stage read port: youngest in-flight writer match, hazard and forward select.
// Optional GRF_WB_BYPASS_EN: a match in the last stage reads through the GRF (fwd 0).
module sb_port_match
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int FSW   = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:1] entry,
    input  logic [AW-1:0]         raddr,
    input  logic                  rused,
    input  logic [TW-1:0]         tuse,
    output logic                  hazard,
    output logic [FSW-1:0]        fwd
);

    logic           hit;
    logic [FSW-1:0] hit_stg;
    logic [TW-1:0]  hit_tnew;

    // Scan oldest to youngest so the youngest (lowest stage) match wins.
    always_comb begin
        hit      = 1'b0;
        hit_stg  = '0;
        hit_tnew = '0;
        for (int k = DEPTH-1; k >= 1; k--) begin
            if (rused && raddr != '0 && entry[k].valid && entry[k].addr == raddr) begin
                hit      = 1'b1;
                hit_stg  = FSW'(k);
                hit_tnew = entry[k].tnew;
            end
        end
    end

    assign hazard = hit && (hit_tnew > tuse);

    always_comb begin
        fwd = '0;
        if (hit && hit_tnew == '0)
            fwd = hit_stg;
`ifdef GRF_WB_BYPASS_EN
        if (hit_stg == FSW'(DEPTH-1))
            fwd = '0;
`endif
    end

endmodule

// File: rtl/d_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: shift register of in-flight writers E..W,
// per-port match units and global stall. Option macro: GRF_WB_BYPASS_EN.
module d_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter  int NRD   = 2,
    parameter  int DEPTH = 4,
    localparam int FSW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               d_valid,
    input  logic               d_regwrite,
    input  logic [AW-1:0]      d_waddr,
    input  logic [TW-1:0]      d_tnew,
    input  logic [NRD*AW-1:0]  d_raddr,
    input  logic [NRD-1:0]     d_rused,
    input  logic [NRD*TW-1:0]  d_tuse,
    input  logic               d_mdu_class,
    input  logic               mdu_busy,
    input  logic               flush,
    output logic               stall,
    output logic [NRD*FSW-1:0] fwd_sel
);

    sb_entry_t [DEPTH-1:1] entry;
    logic [NRD-1:0]        hazard;
    logic [NRD*FSW-1:0]    fwd_raw;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        sb_port_match #(.DEPTH(DEPTH), .FSW(FSW)) u_match (
            .entry  (entry),
            .raddr  (d_raddr[p*AW +: AW]),
            .rused  (d_rused[p]),
            .tuse   (d_tuse[p*TW +: TW]),
            .hazard (hazard[p]),
            .fwd    (fwd_raw[p*FSW +: FSW])
        );
    end

    assign stall   = (|hazard) | (d_mdu_class & mdu_busy);
    assign fwd_sel = stall ? '0 : fwd_raw;

    // The last stage always takes the shifted entry, even on flush: it commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry <= '0;
        end else begin
            entry[STG_E] <= '{valid: d_valid & d_regwrite & (d_waddr != '0) & ~stall & ~flush,
                              addr:  d_waddr,
                              tnew:  d_tnew};
            for (int k = 2; k <= DEPTH-1; k++) begin
                if (flush && k <= DEPTH-2)
                    entry[k] <= '0;
                else
                    entry[k] <= '{valid: entry[k-1].valid,
                                  addr:  entry[k-1].addr,
                                  tnew:  sat_dec(entry[k-1].tnew)};
            end
        end
    end

endmodule

// File: tb/tb_d_hazard_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a record-list model.
module tb_d_hazard_scoreboard;
    localparam int NRD = 2;
    localparam int DEPTH = 4;
    localparam int AW = 5;
    localparam int TW = 2;
    localparam int FSW = $clog2(DEPTH);
`ifdef GRF_WB_BYPASS_EN
    localparam logic [1:0] W_FWD = 2'd0;
`else
    localparam logic [1:0] W_FWD = 2'd3;
`endif

    logic clk = 0;
    logic reset, d_valid, d_regwrite, d_mdu_class, mdu_busy, flush;
    logic [AW-1:0] d_waddr;
    logic [TW-1:0] d_tnew;
    logic [NRD*AW-1:0] d_raddr;
    logic [NRD-1:0] d_rused;
    logic [NRD*TW-1:0] d_tuse;
    logic stall;
    logic [NRD*FSW-1:0] fwd_sel;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;
    int cyc_n = 0;

    d_hazard_scoreboard #(.NRD(NRD), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_regwrite(d_regwrite),
        .d_waddr(d_waddr), .d_tnew(d_tnew), .d_raddr(d_raddr), .d_rused(d_rused),
        .d_tuse(d_tuse), .d_mdu_class(d_mdu_class), .mdu_busy(mdu_busy),
        .flush(flush), .stall(stall), .fwd_sel(fwd_sel)
    );

    always #5 clk = ~clk;

    // Model: list of in-flight writers with their original Tnew and current stage.
    typedef struct { int addr; int tnew0; int stg; } rec_t;
    rec_t q[$];

    function automatic int rem_tnew(rec_t r);
        int t = r.tnew0 - (r.stg - 1);
        return (t < 0) ? 0 : t;
    endfunction

    function automatic void model_out(output bit st, output logic [NRD*FSW-1:0] fs);
        st = d_mdu_class && mdu_busy;
        fs = '0;
        for (int p = 0; p < NRD; p++) begin
            int ra = int'(d_raddr[p*AW +: AW]);
            int tu = int'(d_tuse[p*TW +: TW]);
            int best = -1;
            if (!d_rused[p] || ra == 0) continue;
            foreach (q[i])
                if (q[i].addr == ra && (best < 0 || q[i].stg < q[best].stg)) best = i;
            if (best < 0) continue;
            if (rem_tnew(q[best]) > tu) st = 1;
            else if (rem_tnew(q[best]) == 0) begin
`ifdef GRF_WB_BYPASS_EN
                if (q[best].stg != DEPTH-1) fs[p*FSW +: FSW] = FSW'(q[best].stg);
`else
                fs[p*FSW +: FSW] = FSW'(q[best].stg);
`endif
            end
        end
        if (st) fs = '0;
    endfunction

    function automatic void model_step();
        bit st;
        logic [NRD*FSW-1:0] fs;
        rec_t nq[$];
        if (reset) begin
            q.delete();
            return;
        end
        model_out(st, fs);
        foreach (q[i]) begin
            rec_t r = q[i];
            r.stg++;
            if (r.stg <= DEPTH-1 && !(flush && r.stg <= DEPTH-2)) nq.push_back(r);
        end
        if (d_valid && d_regwrite && d_waddr != 0 && !st && !flush)
            nq.push_back('{int'(d_waddr), int'(d_tnew), 1});
        q = nq;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        bit es;
        logic [NRD*FSW-1:0] ef;
        if (chk_en) begin
            model_out(es, ef);
            tests++;
            if (stall !== es || fwd_sel !== ef) begin
                fails++;
                $display("FAIL model cycle %0d: stall=%b fwd_sel=%h, expected stall=%b fwd_sel=%h",
                         cyc_n, stall, fwd_sel, es, ef);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        model_step();
    endtask

    task automatic idle();
        d_valid = 0; d_regwrite = 0; d_waddr = 0; d_tnew = 0;
        d_raddr = 0; d_rused = 0; d_tuse = 0;
        d_mdu_class = 0; mdu_busy = 0; flush = 0;
    endtask

    task automatic wr(input int a, input int t);
        d_valid = 1; d_regwrite = 1; d_waddr = AW'(a); d_tnew = TW'(t);
    endtask

    task automatic rd(input int p, input int a, input int tu);
        d_valid = 1;
        d_raddr[p*AW +: AW] = AW'(a);
        d_rused[p] = 1;
        d_tuse[p*TW +: TW] = TW'(tu);
    endtask

    task automatic chk(input string nm, input bit es, input logic [NRD*FSW-1:0] ef);
        #2;
        tests++;
        if (stall !== es || fwd_sel !== ef) begin
            fails++;
            $display("FAIL %s: stall=%b fwd_sel=%h, expected stall=%b fwd_sel=%h",
                     nm, stall, fwd_sel, es, ef);
        end
    endtask

    task automatic drain();
        repeat (4) begin cyc(); idle(); end
    endtask

    initial begin
        idle();
        reset = 1; wr(8, 2);
        @(posedge clk); #1; cyc_n++; model_step(); chk_en = 1;
        chk("reset_c1", 0, 4'h0);
        cyc(); chk("reset_c2", 0, 4'h0);
        cyc(); reset = 0; idle(); rd(0, 8, 0);
        chk("reset_empty", 0, 4'h0);

        // load-use: two stall cycles then forward from W
        cyc(); idle(); wr(8, 2); chk("lw_issue", 0, 4'h0);
        cyc(); idle(); wr(10, 1); rd(0, 8, 0); chk("lw_stall1", 1, 4'h0);
        cyc(); chk("lw_stall2", 1, 4'h0);
        cyc(); chk("lw_fwd_w", 0, {2'd0, W_FWD});
        drain();

        // ALU result to a branch: one stall then forward from M
        wr(9, 1);
        cyc(); idle(); rd(0, 9, 0); chk("br_stall", 1, 4'h0);
        cyc(); chk("br_fwd_m", 0, 4'h2);
        drain();

        // youngest writer wins; $0 never forwards
        wr(5, 0);
        cyc(); idle(); wr(5, 0);
        cyc(); idle(); rd(0, 5, 0); rd(1, 0, 0); chk("youngest", 0, 4'h1);
        drain();

        // flush kills E/M, W still commits
        wr(6, 0);
        cyc(); idle(); wr(4, 2);
        cyc(); idle(); flush = 1; chk("flush_cyc", 0, 4'h0);
        cyc(); idle(); rd(0, 4, 0); rd(1, 6, 0); chk("after_flush", 0, {W_FWD, 2'd0});
        drain();

        // MDU busy stalls only MDU-class instructions
        d_valid = 1; d_mdu_class = 1; mdu_busy = 1; d_regwrite = 1; d_waddr = 12; d_tnew = 1;
        chk("mdu_busy0", 1, 4'h0);
        cyc(); chk("mdu_busy1", 1, 4'h0);
        cyc(); mdu_busy = 0; chk("mdu_done", 0, 4'h0);
        cyc(); idle(); d_valid = 1; mdu_busy = 1; chk("non_mdu", 0, 4'h0);
        drain();

        // reset while stalled
        wr(7, 3);
        cyc(); idle(); rd(0, 7, 0); chk("pre_rst_stall", 1, 4'h0);
        reset = 1;
        cyc(); chk("rst_mid_stall", 0, 4'h0);
        d_mdu_class = 1; mdu_busy = 1; chk("rst_mdu", 1, 4'h0);
        cyc(); reset = 0; idle();

        // randomized traffic on a small register set so matches are frequent
        repeat (3000) begin
            cyc();
            idle();
            d_valid = ($urandom_range(0, 7) != 0);
            d_regwrite = $urandom_range(0, 1);
            d_waddr = AW'($urandom_range(0, 3));
            d_tnew = TW'($urandom_range(0, 3));
            for (int p = 0; p < NRD; p++) begin
                d_raddr[p*AW +: AW] = AW'($urandom_range(0, 3));
                d_rused[p] = $urandom_range(0, 1);
                d_tuse[p*TW +: TW] = TW'($urandom_range(0, 3));
            end
            d_mdu_class = ($urandom_range(0, 3) == 0);
            mdu_busy = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 63) == 0);
        end
        cyc();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
